sr_flag_arbiter: RTL and testbench
==================================

# sr_flag_arbiter

Round-robin arbiter and sequencer that shares a bank of SR flag flip-flops between several requesters. Each requester presents a set/reset command addressed to one flag. The block grants one command per clock, applies it to the addressed flag, and flags illegal commands. It sits between control FSMs that raise or clear status bits and the shared SR status register they all read.

## Interface
- NREQ, 4: number of requesters (2..8).
- NFLAG, 8: number of SR flags in the bank (2..32).
- IDXW, clog2(NFLAG): width of one flag index.
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset; reset=0 forces the reset state immediately, independent of clock.
- clr  in  1  synchronous clear of the whole bank, active-high.
- req  in  NREQ  per-requester command valid; held high until granted.
- cmd_s  in  NREQ  per-requester set bit.
- cmd_r  in  NREQ  per-requester reset bit.
- cmd_idx  in  NREQ*IDXW  packed flag indices; requester k uses bits [k*IDXW +: IDXW].
- gnt  out  NREQ  registered one-hot grant; high for exactly one cycle per accepted command.
- q  out  NFLAG  flag values.
- qbar  out  NFLAG  always the bitwise complement of q; never X.
- err  out  1  one-cycle pulse when a granted command is illegal.
- err_src  out  clog2(NREQ)  index of the requester that caused the last err; holds its value between errors.

## Operation
- Reset state: q=0, qbar=all ones, gnt=0, err=0, err_src=0, and the round-robin pointer is 0, so requester 0 has highest priority.
- Arbitration happens every cycle that clr=0. Among requesters with req=1, the winner is the first one found scanning upward from the pointer, wrapping from NREQ-1 to 0.
- After a grant to requester k, the pointer becomes (k+1) mod NREQ. With no requests, the pointer holds.
- Command decode for the granted requester k at flag i=cmd_idx[k]:
  - s=0, r=0: no-op. The grant is still issued and the pointer still advances.
  - s=0, r=1: q[i] becomes 0.
  - s=1, r=0: q[i] becomes 1.
  - s=1, r=1: illegal. q is unchanged, err=1, err_src=k.
  - i >= NFLAG, for any s/r combination: illegal, same response as s=1, r=1.
- At most one flag changes per cycle. Commands from different requesters to the same flag are applied in grant order, so the last grant wins.
- clr=1: on the next edge q=0 and qbar=all ones. No grant is issued that cycle, gnt=0, err=0, and the pointer holds. Pending requests stay pending and are arbitrated after clr drops.
- Requester rules:
  - Hold req, cmd_s, cmd_r and cmd_idx stable until gnt[k] is sampled high.
  - After the grant, either drop req or present the next command; the arbiter treats it as a new request.
  - Changing the command while waiting is not allowed; the result is undefined, but q never goes to X.

## Timing
- Latency: req sampled at edge t produces gnt[k]=1, the q/qbar update and err (if illegal) together at edge t+1. These are visible during cycle t+1.
- Throughput: one command per cycle. With all NREQ requesters continuously requesting, each one is granted exactly once every NREQ cycles (starvation-free).
- gnt, err and err_src are registered; there is no combinational path from req to gnt.
- Reset asserted mid-operation:
  - All outputs take their reset values asynchronously.
  - In-flight grants are lost, and requesters must re-request.
  - On the first rising edge after reset releases, the block arbitrates normally from pointer 0.
- If clr and reset are both asserted, reset dominates.

## Test plan
- Reset, then req=0001 with cmd_s=1 and idx=3 -> one cycle later gnt=0001, q=0x08, qbar=0xF7, err=0.
- req=1111 held for 8 cycles with no-op commands -> gnt sequence 0001,0010,0100,1000,0001,0010,0100,1000.
- Requester 2 issues s=1, r=1 at idx=5 while q=0x20 -> err pulses for one cycle, err_src=2, q stays 0x20, gnt=0100.
- Requester 0 sets idx 7 and requester 1 resets idx 7, both requesting in the same cycle from pointer 0 -> q[7] is 1 after the first edge and 0 after the second.
- q=0xFF, clr=1 for one cycle with req=0010 pending -> q=0x00, gnt=0 that cycle; on the next edge gnt=0010 and the command is applied.
- Drop reset to 0 between clock edges while q=0x5A and gnt is high -> q=0, qbar=0xFF, gnt=0 immediately, before the next edge.

Source files
------------

// File: rtl/sr_flag_arbiter.sv
// -----------------------------------------------------------------------------
// sr_flag_arbiter
//
// Round-robin arbiter in front of a shared bank of SR status flags. Each
// requester presents a set/reset command aimed at one flag. One command is
// granted per clock and applied to its flag. Illegal commands are reported on
// err/err_src. Illegal means s=r=1, or an index beyond the bank.
//
// Parameters
//   NREQ   number of requesters (2..8)
//   NFLAG  number of SR flags (2..32)
//   IDXW   width of one flag index, clog2(NFLAG)
//
// Ports
//   clock    in   rising-edge clock
//   reset    in   asynchronous active-low reset
//   clr      in   synchronous clear of the whole flag bank, no grant that cycle
//   req      in   [NREQ]        per-requester command valid, held until granted
//   cmd_s    in   [NREQ]        per-requester set bit
//   cmd_r    in   [NREQ]        per-requester reset bit
//   cmd_idx  in   [NREQ*IDXW]   packed flag indices, requester k at [k*IDXW +: IDXW]
//   gnt      out  [NREQ]        registered one-hot grant, one cycle per command
//   q        out  [NFLAG]       flag values
//   qbar     out  [NFLAG]       bitwise complement of q
//   err      out                one-cycle pulse for a granted illegal command
//   err_src  out  [clog2(NREQ)] requester behind the most recent err
// -----------------------------------------------------------------------------
module sr_flag_arbiter #(
    parameter int NREQ  = 4,
    parameter int NFLAG = 8,
    parameter int IDXW  = $clog2(NFLAG)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clr,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          cmd_s,
    input  logic [NREQ-1:0]          cmd_r,
    input  logic [NREQ*IDXW-1:0]     cmd_idx,
    output logic [NREQ-1:0]          gnt,
    output logic [NFLAG-1:0]         q,
    output logic [NFLAG-1:0]         qbar,
    output logic                     err,
    output logic [$clog2(NREQ)-1:0]  err_src
);

    localparam int PW = $clog2(NREQ);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [PW-1:0]    ptr_reg;
    logic [PW-1:0]    ptr_next;
    logic [NREQ-1:0]  gnt_reg;
    logic [NREQ-1:0]  gnt_next;
    logic             err_reg;
    logic             err_next;
    logic [PW-1:0]    err_src_reg;
    logic [PW-1:0]    err_src_next;
    logic [NFLAG-1:0] q_reg;
    logic [NFLAG-1:0] q_next;

    // -------------------------------------------------------------------------
    // Round-robin selection
    //
    // Requests at or above the pointer form the "upper" set. If that set is
    // non-empty its lowest member wins. Otherwise the scan has wrapped, and the
    // lowest request overall wins. This is equivalent to scanning upward from
    // the pointer with wrap-around.
    // -------------------------------------------------------------------------
    logic [NREQ-1:0] hi_mask;
    logic [NREQ-1:0] req_hi;
    logic [NREQ-1:0] sel_vec;
    logic            win_valid;
    logic [PW-1:0]   win_idx;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_mask
            assign hi_mask[gi] = (PW'(gi) >= ptr_reg);
        end
    endgenerate

    assign req_hi    = req & hi_mask;
    assign sel_vec   = (|req_hi) ? req_hi : req;
    assign win_valid = |req;

    // Lowest set bit of sel_vec. The loop runs downward so that the last
    // assignment to win_idx is the lowest index.
    always_comb begin
        win_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (sel_vec[k]) begin
                win_idx = PW'(k);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Command decode for the winning requester
    // -------------------------------------------------------------------------
    logic [IDXW-1:0] idx_arr [NREQ];

    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign idx_arr[gi] = cmd_idx[gi*IDXW +: IDXW];
        end
    endgenerate

    logic            sel_s;
    logic            sel_r;
    logic [IDXW-1:0] sel_idx;
    logic            idx_bad;
    logic            illegal;
    logic            accept;
    logic            cmd_ok;

    assign sel_s   = cmd_s[win_idx];
    assign sel_r   = cmd_r[win_idx];
    assign sel_idx = idx_arr[win_idx];

    // An out-of-range index is only possible when NFLAG is not a power of two.
    // Skipping the compare otherwise avoids a constant-false comparison.
    generate
        if (NFLAG < (1 << IDXW)) begin : g_idx_range
            assign idx_bad = ({1'b0, sel_idx} >= (IDXW+1)'(NFLAG));
        end else begin : g_idx_full
            assign idx_bad = 1'b0;
        end
    endgenerate

    // A grant happens whenever someone requests and the bank is not being
    // cleared. A no-op (s=r=0) still consumes its grant.
    assign accept  = win_valid & ~clr;
    assign illegal = (sel_s & sel_r) | idx_bad;
    assign cmd_ok  = accept & ~illegal;

    // -------------------------------------------------------------------------
    // Flag bank: per-flag set/reset strobes. At most one strobe is active per
    // cycle, because only the single granted command can drive them.
    // -------------------------------------------------------------------------
    logic [NFLAG-1:0] set_mask;
    logic [NFLAG-1:0] rst_mask;

    generate
        for (gi = 0; gi < NFLAG; gi++) begin : g_flag
            logic hit;
            assign hit          = cmd_ok & (sel_idx == IDXW'(gi));
            assign set_mask[gi] = hit & sel_s;
            assign rst_mask[gi] = hit & sel_r;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        ptr_next     = ptr_reg;
        gnt_next     = '0;
        err_next     = 1'b0;
        err_src_next = err_src_reg;
        q_next       = (q_reg | set_mask) & ~rst_mask;

        if (clr) begin
            q_next = '0;
        end

        if (accept) begin
            gnt_next = NREQ'(1) << win_idx;
            ptr_next = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + PW'(1);
            if (illegal) begin
                err_next     = 1'b1;
                err_src_next = win_idx;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr_reg     <= '0;
            gnt_reg     <= '0;
            err_reg     <= 1'b0;
            err_src_reg <= '0;
            q_reg       <= '0;
        end else begin
            ptr_reg     <= ptr_next;
            gnt_reg     <= gnt_next;
            err_reg     <= err_next;
            err_src_reg <= err_src_next;
            q_reg       <= q_next;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign gnt     = gnt_reg;
    assign q       = q_reg;
    assign qbar    = ~q_reg;
    assign err     = err_reg;
    assign err_src = err_src_reg;

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sr_flag_arbiter
//
// Directed bench for sr_flag_arbiter (NREQ=4, NFLAG=8). It drives commands just
// after a rising edge and samples outputs 1 time unit after the next edge.
// Expected values are worked out by hand.
// -----------------------------------------------------------------------------
module tb_sr_flag_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        clr;
    logic [3:0]  req;
    logic [3:0]  cmd_s;
    logic [3:0]  cmd_r;
    logic [11:0] cmd_idx;
    logic [3:0]  gnt;
    logic [7:0]  q;
    logic [7:0]  qbar;
    logic        err;
    logic [1:0]  err_src;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    sr_flag_arbiter #(
        .NREQ  (4),
        .NFLAG (8)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .clr     (clr),
        .req     (req),
        .cmd_s   (cmd_s),
        .cmd_r   (cmd_r),
        .cmd_idx (cmd_idx),
        .gnt     (gnt),
        .q       (q),
        .qbar    (qbar),
        .err     (err),
        .err_src (err_src)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_cmd(input int k, input logic s, input logic r, input logic [2:0] idx);
        cmd_s[k]           = s;
        cmd_r[k]           = r;
        cmd_idx[k*3 +: 3]  = idx;
    endtask

    // Advance one clock and log the resulting transaction.
    task automatic step();
        @(posedge clock);
        #1;
        $display("t=%0t req=%b gnt=%b q=%h qbar=%h err=%b err_src=%0d",
                 $time, req, gnt, q, qbar, err, err_src);
    endtask

    logic [7:0] exp_q;
    logic [3:0] exp_g;

    initial begin
        reset   = 1'b0;
        clr     = 1'b0;
        req     = '0;
        cmd_s   = '0;
        cmd_r   = '0;
        cmd_idx = '0;

        // Reset state
        step();
        step();
        check("rst_q",       q,       8'h00);
        check("rst_qbar",    qbar,    8'hFF);
        check("rst_gnt",     gnt,     4'b0000);
        check("rst_err",     err,     1'b0);
        check("rst_err_src", err_src, 2'd0);
        reset = 1'b1;

        // Requester 0 sets flag 3
        req = 4'b0001;
        set_cmd(0, 1'b1, 1'b0, 3'd3);
        step();
        check("set3_gnt",  gnt,  4'b0001);
        check("set3_q",    q,    8'h08);
        check("set3_qbar", qbar, 8'hF7);
        check("set3_err",  err,  1'b0);
        req = 4'b0000;
        step();
        check("idle_gnt", gnt, 4'b0000);

        // Pointer is 1. A no-op from requester 3 brings it back to 0.
        req = 4'b1000;
        set_cmd(3, 1'b0, 1'b0, 3'd0);
        step();
        check("noop3_gnt", gnt, 4'b1000);
        check("noop3_q",   q,   8'h08);

        // All four requesting no-ops: strict rotation from requester 0
        req = 4'b1111;
        for (int k = 0; k < 4; k++) set_cmd(k, 1'b0, 1'b0, 3'd0);
        for (int i = 0; i < 8; i++) begin
            step();
            exp_g = 4'b0001 << (i % 4);
            check("rr_gnt", gnt, exp_g);
            check("rr_q",   q,   8'h08);
        end
        req = 4'b0000;

        // Pointer 0: clear flag 3, then set flag 5 -> q=0x20
        req = 4'b0001;
        set_cmd(0, 1'b0, 1'b1, 3'd3);
        step();
        check("rst3_gnt", gnt, 4'b0001);
        check("rst3_q",   q,   8'h00);
        req = 4'b0010;
        set_cmd(1, 1'b1, 1'b0, 3'd5);
        step();
        check("set5_gnt", gnt, 4'b0010);
        check("set5_q",   q,   8'h20);

        // Illegal s=r=1 from requester 2
        req = 4'b0100;
        set_cmd(2, 1'b1, 1'b1, 3'd5);
        step();
        check("ill_gnt",     gnt,     4'b0100);
        check("ill_err",     err,     1'b1);
        check("ill_err_src", err_src, 2'd2);
        check("ill_q",       q,       8'h20);
        req = 4'b0000;
        step();
        check("ill_err_pulse", err,     1'b0);
        check("ill_src_hold",  err_src, 2'd2);
        check("ill_gnt_off",   gnt,     4'b0000);

        // Pointer is 3. A no-op from requester 3 brings it to 0.
        req = 4'b1000;
        step();
        check("noop3b_gnt", gnt, 4'b1000);

        // Same flag, two requesters: grant order, last one wins
        req = 4'b0011;
        set_cmd(0, 1'b1, 1'b0, 3'd7);
        set_cmd(1, 1'b0, 1'b1, 3'd7);
        step();
        check("same1_gnt", gnt, 4'b0001);
        check("same1_q",   q,   8'hA0);
        req = 4'b0010;
        step();
        check("same2_gnt", gnt, 4'b0010);
        check("same2_q",   q,   8'h20);
        req = 4'b0000;

        // Requester 0 alone sets every flag, one per cycle
        exp_q = 8'h20;
        req   = 4'b0001;
        for (int i = 0; i < 8; i++) begin
            set_cmd(0, 1'b1, 1'b0, 3'(i));
            step();
            exp_q = exp_q | (8'h01 << i);
            check("fill_gnt", gnt, 4'b0001);
            check("fill_q",   q,   exp_q);
        end

        // clr with requester 1 pending: no grant, bank cleared
        clr = 1'b1;
        req = 4'b0010;
        set_cmd(1, 1'b1, 1'b0, 3'd4);
        step();
        check("clr_q",    q,    8'h00);
        check("clr_qbar", qbar, 8'hFF);
        check("clr_gnt",  gnt,  4'b0000);
        check("clr_err",  err,  1'b0);
        clr = 1'b0;
        step();
        check("postclr_gnt", gnt, 4'b0010);
        check("postclr_q",   q,   8'h10);
        req = 4'b0000;

        // Build q=0x5A with requester 0
        req = 4'b0001;
        set_cmd(0, 1'b1, 1'b0, 3'd1);
        step();
        check("b1_q", q, 8'h12);
        set_cmd(0, 1'b1, 1'b0, 3'd3);
        step();
        check("b3_q", q, 8'h1A);
        set_cmd(0, 1'b1, 1'b0, 3'd6);
        step();
        check("b6_q",   q,   8'h5A);
        check("b6_gnt", gnt, 4'b0001);

        // Asynchronous reset between edges
        #2;
        reset = 1'b0;
        #1;
        check("arst_q",    q,    8'h00);
        check("arst_qbar", qbar, 8'hFF);
        check("arst_gnt",  gnt,  4'b0000);
        check("arst_err",  err,  1'b0);

        // After release, arbitration restarts from pointer 0
        req = 4'b1001;
        set_cmd(0, 1'b0, 1'b0, 3'd0);
        set_cmd(3, 1'b0, 1'b0, 3'd0);
        @(negedge clock);
        reset = 1'b1;
        step();
        check("rel_gnt", gnt, 4'b0001);
        check("rel_q",   q,   8'h00);
        req = 4'b0000;
        step();
        check("end_gnt", gnt, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
